// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between CPU (port 0) and debug/DMA (port 1).
// Latency: gnt one edge after req, registered mem_* for one ACCESS cycle, rdata/rvalid the edge after; 1 access per 2 cycles peak.
// Backpressure: requesters hold req+cmd until gnt. Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority (no rr_ptr).
module dmem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   grant;
  logic   win;
  logic   cmd_we;
  logic   cmd_owner;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic   rr_ptr;
`endif

  always_comb begin
    grant     = 1'b0;
    win       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
`ifdef DMEM_ARB_FIXED_PRIO_EN
          win = (req == 2'b10);
`else
          win = (req == 2'b10) | ((req == 2'b11) & rr_ptr);
`endif
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // mem_addr/mem_wdata double as the command registers: they hold outside ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= 2'b00;
      rvalid    <= 2'b00;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_we    <= 1'b0;
      cmd_owner <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      gnt    <= 2'b00;
      rvalid <= 2'b00;
      if (grant) begin
        gnt       <= win ? 2'b10 : 2'b01;
        cmd_we    <= we[win];
        cmd_owner <= win;
        mem_read  <= ~we[win];
        mem_write <= we[win];
        mem_addr  <= win ? addr1 : addr0;
        mem_wdata <= win ? wdata1 : wdata0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        rr_ptr    <= ~win;
`endif
      end else if (state == ACCESS) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (!cmd_we) begin
          rdata  <= mem_rdata;
          rvalid <= cmd_owner ? 2'b10 : 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64x32 memory; expectations queued at issue, checked by a negedge monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_clear = 1'b1;
  logic [31:0] mem [64];

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } acc_t;
  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] data;
  } rv_t;

  logic [1:0] exp_gnt[$];
  acc_t       exp_acc[$];
  rv_t        exp_rv[$];

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory initial contents are 0xA5000000 + word index.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + i;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 2'b00) begin
        n_tests++;
        if (exp_gnt.size() == 0) begin
          n_fail++;
          $display("FAIL gnt_unexpected: got %b expected none", gnt);
        end else begin
          logic [1:0] eg;
          eg = exp_gnt.pop_front();
          if (gnt !== eg) begin
            n_fail++;
            $display("FAIL gnt: got %b expected %b", gnt, eg);
          end
        end
      end
      if (mem_read || mem_write) begin
        n_tests++;
        if (exp_acc.size() == 0) begin
          n_fail++;
          $display("FAIL mem_unexpected: got rd=%b wr=%b addr=%0d expected none", mem_read, mem_write, mem_addr);
        end else begin
          acc_t ea;
          ea = exp_acc.pop_front();
          if (mem_write !== ea.we || mem_read !== ~ea.we || mem_addr !== ea.addr ||
              (ea.we && mem_wdata !== ea.wdata)) begin
            n_fail++;
            $display("FAIL mem_access: got rd=%b wr=%b addr=%0d wdata=0x%08h expected we=%b addr=%0d wdata=0x%08h",
                     mem_read, mem_write, mem_addr, mem_wdata, ea.we, ea.addr, ea.wdata);
          end
        end
      end
      if (rvalid != 2'b00) begin
        n_tests++;
        if (exp_rv.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid_unexpected: got %b rdata=0x%08h expected none", rvalid, rdata);
        end else begin
          rv_t er;
          er = exp_rv.pop_front();
          if (rvalid !== er.own || rdata !== er.data) begin
            n_fail++;
            $display("FAIL rvalid: got %b/0x%08h expected %b/0x%08h", rvalid, rdata, er.own, er.data);
          end
        end
      end
    end
  end

  // Called at posedge+1; each port's req drops as soon as its gnt is seen.
  task automatic issue(input logic [1:0] mask, input logic [1:0] wev,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       output int first_lat);
    logic [1:0] pend;
    int cyc;
    pend = mask; cyc = 0; first_lat = -1;
    req = mask; we = wev; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    while (pend != 2'b00 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && gnt[p]) begin
          pend[p] = 1'b0;
          req[p] = 1'b0;
          if (first_lat < 0) first_lat = cyc;
        end
      end
    end
    if (pend != 2'b00) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got pending=%b expected 00", pend);
      req = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0; mem_clear = 1'b0;
    @(posedge clk); #1;

    // Single read, port 0, addr 3
    exp_gnt.push_back(2'b01);
    exp_acc.push_back('{we: 1'b0, addr: 6'd3, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b01, data: 32'hA500_0003});
    issue(2'b01, 2'b00, 6'd3, 6'd0, 32'd0, 32'd0, lat);
    check("single_read_latency", lat, 32'd1);

    // Port 1 write 0xDEADBEEF to 45, then read it back
    exp_gnt.push_back(2'b10);
    exp_acc.push_back('{we: 1'b1, addr: 6'd45, wdata: 32'hDEAD_BEEF});
    issue(2'b10, 2'b10, 6'd0, 6'd45, 32'd0, 32'hDEAD_BEEF, lat);
    check("mem45_after_write", mem[45], 32'hDEAD_BEEF);
    exp_gnt.push_back(2'b10);
    exp_acc.push_back('{we: 1'b0, addr: 6'd45, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b10, data: 32'hDEAD_BEEF});
    issue(2'b10, 2'b00, 6'd0, 6'd45, 32'd0, 32'd0, lat);

    // Contention: req=11 held 8 cycles, reads of 10 (port 0) and 20 (port 1)
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_gnt.push_back(2'b01);
      exp_acc.push_back('{we: 1'b0, addr: 6'd10, wdata: 32'd0});
      exp_rv.push_back('{own: 2'b01, data: 32'hA500_000A});
`else
      exp_gnt.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_acc.push_back('{we: 1'b0, addr: (k % 2 == 0) ? 6'd10 : 6'd20, wdata: 32'd0});
      exp_rv.push_back('{own: (k % 2 == 0) ? 2'b01 : 2'b10,
                         data: (k % 2 == 0) ? 32'hA500_000A : 32'hA500_0014});
`endif
    end
    req = 2'b11; we = 2'b00; addr0 = 6'd10; addr1 = 6'd20;
    repeat (8) @(posedge clk);
    #1 req = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // Withdraw: req1 pulsed only during port 0's ACCESS
    exp_gnt.push_back(2'b01);
    exp_acc.push_back('{we: 1'b0, addr: 6'd7, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b01, data: 32'hA500_0007});
    req = 2'b01; we = 2'b00; addr0 = 6'd7; addr1 = 6'd50;
    @(posedge clk); #1;
    check("withdraw_gnt0", {30'd0, gnt}, 32'd1);
    req = 2'b10;
    @(posedge clk); #1;
    req = 2'b00;
    check("withdraw_no_gnt", {30'd0, gnt}, 32'd0);
    check("withdraw_no_access", {30'd0, mem_read, mem_write}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    // Round-robin pointer must still favour port 1 after port 0's grant
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_gnt.push_back(2'b01);
    exp_acc.push_back('{we: 1'b0, addr: 6'd3, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b01, data: 32'hA500_0003});
    exp_gnt.push_back(2'b10);
    exp_acc.push_back('{we: 1'b0, addr: 6'd45, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b10, data: 32'hDEAD_BEEF});
`else
    exp_gnt.push_back(2'b10);
    exp_acc.push_back('{we: 1'b0, addr: 6'd45, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b10, data: 32'hDEAD_BEEF});
    exp_gnt.push_back(2'b01);
    exp_acc.push_back('{we: 1'b0, addr: 6'd3, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b01, data: 32'hA500_0003});
`endif
    issue(2'b11, 2'b00, 6'd3, 6'd45, 32'd0, 32'd0, lat);

    // Reset during a write ACCESS: outputs clear at once, word 12 untouched
    req = 2'b01; we = 2'b01; addr0 = 6'd12; wdata0 = 32'h1234_5678;
    @(posedge clk); #1;
    check("rstw_gnt_before", {30'd0, gnt}, 32'd1);
    check("rstw_mem_write_before", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b1;
    req = 2'b00;
    #1;
    check("rstw_mem_write", {31'd0, mem_write}, 32'd0);
    check("rstw_mem_read", {31'd0, mem_read}, 32'd0);
    check("rstw_gnt", {30'd0, gnt}, 32'd0);
    check("rstw_rvalid", {30'd0, rvalid}, 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    check("rstw_mem_addr", {26'd0, mem_addr}, 32'd0);
    check("rstw_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    check("rstw_mem12_unchanged", mem[12], 32'hA500_000C);
    rst = 1'b0;
    @(posedge clk); #1;

    // After reset, contention starts with port 0
    exp_gnt.push_back(2'b01);
    exp_acc.push_back('{we: 1'b0, addr: 6'd3, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b01, data: 32'hA500_0003});
    exp_gnt.push_back(2'b10);
    exp_acc.push_back('{we: 1'b0, addr: 6'd45, wdata: 32'd0});
    exp_rv.push_back('{own: 2'b10, data: 32'hDEAD_BEEF});
    issue(2'b11, 2'b00, 6'd3, 6'd45, 32'd0, 32'd0, lat);
    check("post_rst_latency", lat, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("gnt_queue_drained", exp_gnt.size(), 32'd0);
    check("acc_queue_drained", exp_acc.size(), 32'd0);
    check("rv_queue_drained", exp_rv.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
